scarv_cop_dispatch: RTL and testbench

CPU-side dispatch and writeback stage for the SCARV ISE coprocessor. It sits directly upstream and downstream of `scarv_cop_top`:
- Buffers decoded ISE instructions and their RS1 operands from the host CPU pipeline in a small FIFO.
- Drives the `cpu_insn_req`/`cop_insn_ack` request handshake into the COP.
- Tracks in-flight instructions.
- Accepts COP responses and turns them into registered GPR writeback pulses, with flush/abort support.

---
 rtl/scarv_cop_dispatch.sv | 181 ++++++++++++++++++
 tb/tb_scarv_cop_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_dispatch.sv
// CPU-side dispatch FIFO and writeback stage for the SCARV ISE coprocessor.
// Queues decoded instructions, issues them to the COP, and retires COP results as GPR writes.
module scarv_cop_dispatch #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [31:0]              disp_enc,
    input  logic [31:0]              disp_rs1,
    input  logic                     flush,
    output logic                     cpu_insn_req,
    input  logic                     cop_insn_ack,
    output logic [31:0]              cpu_insn_enc,
    output logic [31:0]              cpu_rs1,
    output logic                     cpu_abort_req,
    input  logic                     cop_insn_rsp,
    output logic                     cpu_insn_ack,
    input  logic                     cop_wen,
    input  logic [4:0]               cop_waddr,
    input  logic [31:0]              cop_wdata,
    input  logic [2:0]               cop_result,
    output logic                     wb_valid,
    output logic [4:0]               wb_addr,
    output logic [31:0]              wb_data,
    output logic                     wb_done,
    output logic [2:0]               wb_result,
    output logic                     err_seen,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [2:0]               out_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [2:0]    MAX_OUT_C = 3'(MAX_OUT);

    logic [31:0]   enc_mem_q [DEPTH];
    logic [31:0]   rs1_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [2:0]    out_count_q, out_count_d;
    logic [3:0]    drop_cnt_q,  drop_cnt_d;
    logic          req_hold_q,  req_hold_d;
    logic          abort_q,     abort_d;
    logic          wb_valid_q,  wb_valid_d;
    logic          wb_done_q,   wb_done_d;
    logic [4:0]    wb_addr_q,   wb_addr_d;
    logic [31:0]   wb_data_q,   wb_data_d;
    logic [2:0]    wb_result_q, wb_result_d;
    logic          err_seen_q,  err_seen_d;

    logic          full_s;
    logic          empty_s;
    logic          req_s;
    logic          issue_s;
    logic          rsp_ack_s;
    logic          finish_s;
    logic          push_s;
    logic          retire_s;

    // Handshake events derived from registered state and current inputs.
    always_comb begin
        full_s    = (count_q == DEPTH_C);
        empty_s   = (count_q == CNT_ZERO);
        // During a flush only an already-held head may keep requesting.
        req_s     = flush ? req_hold_q
                          : (req_hold_q || (!empty_s && (out_count_q < MAX_OUT_C)));
        issue_s   = req_s && cop_insn_ack;
        rsp_ack_s = (out_count_q != 3'd0);
        finish_s  = cop_insn_rsp && rsp_ack_s;
        push_s    = disp_valid && !full_s && !flush;
        retire_s  = finish_s && (drop_cnt_q == 4'd0);
    end

    // FIFO pointers, occupancy, in-flight count, drop bookkeeping and abort.
    always_comb begin
        rd_ptr_d   = issue_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        req_hold_d = req_s && !cop_insn_ack;
        abort_d    = flush;

        case ({issue_s, finish_s})
            2'b10:   out_count_d = out_count_q + 3'd1;
            2'b01:   out_count_d = out_count_q - 3'd1;
            default: out_count_d = out_count_q;
        endcase

        if (flush) begin
            // Keep only a held head; it must still be issued to the COP.
            wr_ptr_d   = req_hold_q ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            count_d    = (req_hold_q && !issue_s) ? CNT_ONE : CNT_ZERO;
            drop_cnt_d = {1'b0, out_count_d} + {3'b000, (req_hold_q && !cop_insn_ack)};
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            case ({push_s, issue_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            drop_cnt_d = (finish_s && (drop_cnt_q != 4'd0)) ? (drop_cnt_q - 4'd1) : drop_cnt_q;
        end
    end

    // Writeback fields, captured one cycle after a non-dropped finish.
    always_comb begin
        wb_done_d   = retire_s;
        wb_valid_d  = retire_s && cop_wen && (cop_waddr != 5'd0);
        wb_result_d = retire_s   ? cop_result : wb_result_q;
        wb_addr_d   = wb_valid_d ? cop_waddr  : wb_addr_q;
        wb_data_d   = wb_valid_d ? cop_wdata  : wb_data_q;
        if (flush) begin
            err_seen_d = 1'b0;
        end else begin
            err_seen_d = err_seen_q || (retire_s && (cop_result != 3'd0));
        end
    end

    // FIFO storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge g_clk) begin
        if (push_s) begin
            enc_mem_q[wr_ptr_q] <= disp_enc;
            rs1_mem_q[wr_ptr_q] <= disp_rs1;
        end
    end

    // Control and writeback state registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= CNT_ZERO;
            out_count_q <= 3'd0;
            drop_cnt_q  <= 4'd0;
            req_hold_q  <= 1'b0;
            abort_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_addr_q   <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_result_q <= 3'd0;
            err_seen_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
            drop_cnt_q  <= drop_cnt_d;
            req_hold_q  <= req_hold_d;
            abort_q     <= abort_d;
            wb_valid_q  <= wb_valid_d;
            wb_done_q   <= wb_done_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_result_q <= wb_result_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign disp_ready    = !full_s;
    assign cpu_insn_req  = req_s;
    assign cpu_insn_enc  = enc_mem_q[rd_ptr_q];
    assign cpu_rs1       = rs1_mem_q[rd_ptr_q];
    assign cpu_abort_req = abort_q;
    assign cpu_insn_ack  = rsp_ack_s;
    assign wb_valid      = wb_valid_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign wb_done       = wb_done_q;
    assign wb_result     = wb_result_q;
    assign err_seen      = err_seen_q;
    assign q_count       = count_q;
    assign out_count     = out_count_q;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Directed bench for scarv_cop_dispatch: instance a (DEPTH 4, MAX_OUT 2), instance b (DEPTH 4, MAX_OUT 3).
module tb_scarv_cop_dispatch;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b1;
    logic        disp_valid = 1'b0;
    logic [31:0] disp_enc = 32'd0;
    logic [31:0] disp_rs1 = 32'd0;
    logic        flush = 1'b0;
    logic        cop_insn_ack = 1'b0;
    logic        cop_insn_rsp = 1'b0;
    logic        cop_wen = 1'b0;
    logic [4:0]  cop_waddr = 5'd0;
    logic [31:0] cop_wdata = 32'd0;
    logic [2:0]  cop_result = 3'd0;

    logic        a_disp_ready, a_req, a_abort, a_ack, a_wb_valid, a_wb_done, a_err;
    logic [31:0] a_enc, a_rs1, a_wb_data;
    logic [4:0]  a_wb_addr;
    logic [2:0]  a_wb_result, a_out_count, a_q_count;

    logic        b_disp_ready, b_req, b_abort, b_ack, b_wb_valid, b_wb_done, b_err;
    logic [31:0] b_enc, b_rs1, b_wb_data;
    logic [4:0]  b_wb_addr;
    logic [2:0]  b_wb_result, b_out_count, b_q_count;

    int tests = 0;
    int fails = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_dispatch #(.DEPTH(4), .MAX_OUT(2)) u_dut_a (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .disp_valid(disp_valid), .disp_ready(a_disp_ready), .disp_enc(disp_enc), .disp_rs1(disp_rs1),
        .flush(flush), .cpu_insn_req(a_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(a_enc), .cpu_rs1(a_rs1), .cpu_abort_req(a_abort),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(a_ack),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata), .cop_result(cop_result),
        .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .wb_data(a_wb_data), .wb_done(a_wb_done),
        .wb_result(a_wb_result), .err_seen(a_err), .q_count(a_q_count), .out_count(a_out_count)
    );

    scarv_cop_dispatch #(.DEPTH(4), .MAX_OUT(3)) u_dut_b (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .disp_valid(disp_valid), .disp_ready(b_disp_ready), .disp_enc(disp_enc), .disp_rs1(disp_rs1),
        .flush(flush), .cpu_insn_req(b_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(b_enc), .cpu_rs1(b_rs1), .cpu_abort_req(b_abort),
        .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(b_ack),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata), .cop_result(cop_result),
        .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .wb_data(b_wb_data), .wb_done(b_wb_done),
        .wb_result(b_wb_result), .err_seen(b_err), .q_count(b_q_count), .out_count(b_out_count)
    );

    task automatic step;
        @(posedge g_clk);
        #1;
    endtask

    task automatic clear_inputs;
        disp_valid = 1'b0; disp_enc = 32'd0; disp_rs1 = 32'd0; flush = 1'b0;
        cop_insn_ack = 1'b0; cop_insn_rsp = 1'b0; cop_wen = 1'b0;
        cop_waddr = 5'd0; cop_wdata = 32'd0; cop_result = 3'd0;
    endtask

    task automatic do_reset;
        clear_inputs();
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
    endtask

    task automatic push_one(input logic [31:0] e, input logic [31:0] r);
        disp_valid = 1'b1; disp_enc = e; disp_rs1 = r;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        @(negedge g_clk);
        g_resetn = 1'b0;
        #1;
        tests++; if (a_q_count !== 3'd0)   begin fails++; $display("FAIL reset_q_count: got %0d want 0", a_q_count); end
        tests++; if (a_out_count !== 3'd0) begin fails++; $display("FAIL reset_out_count: got %0d want 0", a_out_count); end
        tests++; if (a_disp_ready !== 1'b1) begin fails++; $display("FAIL reset_disp_ready: got %b want 1", a_disp_ready); end
        tests++; if ({a_req, a_abort, a_ack, a_wb_valid, a_wb_done, a_err} !== 6'b0)
            begin fails++; $display("FAIL reset_ctrl: got %b want 000000", {a_req, a_abort, a_ack, a_wb_valid, a_wb_done, a_err}); end
        tests++; if ({a_wb_addr, a_wb_data, a_wb_result} !== 40'd0)
            begin fails++; $display("FAIL reset_wb_fields: got %h/%h/%h want 0", a_wb_addr, a_wb_data, a_wb_result); end
        step();
        g_resetn = 1'b1;
    endtask

    task automatic test_basic;
        int n_valid;
        int bad_fields;
        do_reset();
        cop_insn_ack = 1'b1;
        push_one(32'h0000_1000, 32'h0000_0001);
        push_one(32'h0000_1001, 32'h0000_0002);
        push_one(32'h0000_1002, 32'h0000_0003);
        tests++; if (a_out_count !== 3'd2) begin fails++; $display("FAIL basic_out_at_max: got %0d want 2", a_out_count); end
        tests++; if (a_q_count !== 3'd1)   begin fails++; $display("FAIL basic_q_waiting: got %0d want 1", a_q_count); end
        tests++; if (a_req !== 1'b0)       begin fails++; $display("FAIL basic_req_at_max: got %b want 0", a_req); end
        cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd5; cop_wdata = 32'hDEAD_BEEF;
        n_valid = 0; bad_fields = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (a_wb_valid === 1'b1) begin
                n_valid++;
                if (a_wb_addr !== 5'd5 || a_wb_data !== 32'hDEAD_BEEF) bad_fields++;
            end
        end
        cop_insn_rsp = 1'b0;
        tests++; if (n_valid != 3)   begin fails++; $display("FAIL basic_wb_pulses: got %0d want 3", n_valid); end
        tests++; if (bad_fields != 0) begin fails++; $display("FAIL basic_wb_fields: got %0d bad want 0", bad_fields); end
        tests++; if (a_wb_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_wb_data: got %h want deadbeef", a_wb_data); end
        tests++; if (a_q_count !== 3'd0 || a_out_count !== 3'd0)
            begin fails++; $display("FAIL basic_drained: got q=%0d out=%0d want 0/0", a_q_count, a_out_count); end
    endtask

    task automatic test_fill;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h0000_2000 + 32'(i), 32'h0000_0020 + 32'(i));
        tests++; if (a_disp_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_full: got %b want 0", a_disp_ready); end
        tests++; if (a_q_count !== 3'd4)    begin fails++; $display("FAIL fill_q_full: got %0d want 4", a_q_count); end
        disp_valid = 1'b1; disp_enc = 32'h0000_2004; disp_rs1 = 32'h0000_0024;
        step();
        tests++; if (a_q_count !== 3'd4)          begin fails++; $display("FAIL fill_refused: got %0d want 4", a_q_count); end
        tests++; if (a_enc !== 32'h0000_2000)     begin fails++; $display("FAIL fill_head0: got %h want 00002000", a_enc); end
        cop_insn_ack = 1'b1;
        #1;
        tests++; if (a_disp_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_on_pop: got %b want 0", a_disp_ready); end
        step();
        cop_insn_ack = 1'b0;
        tests++; if (a_q_count !== 3'd3 || a_out_count !== 3'd1)
            begin fails++; $display("FAIL fill_after_issue: got q=%0d out=%0d want 3/1", a_q_count, a_out_count); end
        tests++; if (a_disp_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_freed: got %b want 1", a_disp_ready); end
        tests++; if (a_enc !== 32'h0000_2001) begin fails++; $display("FAIL fill_head1: got %h want 00002001", a_enc); end
        step();
        disp_valid = 1'b0;
        tests++; if (a_q_count !== 3'd4) begin fails++; $display("FAIL fill_fifth_taken: got %0d want 4", a_q_count); end
    endtask

    task automatic test_hold;
        do_reset();
        push_one(32'h0000_3000, 32'h0000_0030);
        for (int i = 0; i < 3; i++) begin
            tests++; if (a_req !== 1'b1 || a_enc !== 32'h0000_3000 || a_rs1 !== 32'h0000_0030)
                begin fails++; $display("FAIL hold_stable_%0d: got req=%b enc=%h rs1=%h want 1/00003000/00000030", i, a_req, a_enc, a_rs1); end
            disp_valid = (i == 0); disp_enc = 32'h0000_3001; disp_rs1 = 32'h0000_0031;
            step();
        end
        disp_valid = 1'b0;
        cop_insn_ack = 1'b1;
        #1;
        tests++; if (a_req !== 1'b1 || a_enc !== 32'h0000_3000)
            begin fails++; $display("FAIL hold_issue_cycle: got req=%b enc=%h want 1/00003000", a_req, a_enc); end
        step();
        cop_insn_ack = 1'b0;
        tests++; if (a_out_count !== 3'd1) begin fails++; $display("FAIL hold_out_count: got %0d want 1", a_out_count); end
        tests++; if (a_q_count !== 3'd1 || a_enc !== 32'h0000_3001)
            begin fails++; $display("FAIL hold_next_head: got q=%0d enc=%h want 1/00003001", a_q_count, a_enc); end
    endtask

    task automatic test_max_out;
        int issues;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h0000_4000 + 32'(i), 32'h0000_0040 + 32'(i));
        cop_insn_ack = 1'b1;
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_req === 1'b1) issues++;
            step();
        end
        tests++; if (issues != 2) begin fails++; $display("FAIL maxout_issues: got %0d want 2", issues); end
        tests++; if (a_out_count !== 3'd2 || a_q_count !== 3'd2 || a_req !== 1'b0)
            begin fails++; $display("FAIL maxout_stall: got out=%0d q=%0d req=%b want 2/2/0", a_out_count, a_q_count, a_req); end
        cop_insn_rsp = 1'b1;
        #1;
        tests++; if (a_req !== 1'b0) begin fails++; $display("FAIL maxout_finish_same_cycle: got req=%b want 0", a_req); end
        step();
        cop_insn_rsp = 1'b0;
        tests++; if (a_wb_done !== 1'b1 || a_out_count !== 3'd1)
            begin fails++; $display("FAIL maxout_retire: got done=%b out=%0d want 1/1", a_wb_done, a_out_count); end
        tests++; if (a_req !== 1'b1 || a_enc !== 32'h0000_4002)
            begin fails++; $display("FAIL maxout_rereq: got req=%b enc=%h want 1/00004002", a_req, a_enc); end
        step();
        cop_insn_ack = 1'b0;
        tests++; if (a_out_count !== 3'd2 || a_q_count !== 3'd1)
            begin fails++; $display("FAIL maxout_third_issue: got out=%0d q=%0d want 2/1", a_out_count, a_q_count); end
    endtask

    task automatic test_flush;
        int fin;
        int dones;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h0000_5000 + 32'(i), 32'h0000_0050 + 32'(i));
        cop_insn_ack = 1'b1;
        step();
        step();
        cop_insn_ack = 1'b0;
        push_one(32'h0000_5004, 32'h0000_0054);
        tests++; if (b_out_count !== 3'd2 || b_q_count !== 3'd3)
            begin fails++; $display("FAIL flush_setup: got out=%0d q=%0d want 2/3", b_out_count, b_q_count); end
        flush = 1'b1;
        #1;
        tests++; if (b_req !== 1'b1) begin fails++; $display("FAIL flush_req_hold: got %b want 1", b_req); end
        step();
        flush = 1'b0;
        tests++; if (b_q_count !== 3'd1 || b_out_count !== 3'd2)
            begin fails++; $display("FAIL flush_counts: got q=%0d out=%0d want 1/2", b_q_count, b_out_count); end
        tests++; if (b_abort !== 1'b1) begin fails++; $display("FAIL flush_abort_pulse: got %b want 1", b_abort); end
        tests++; if (b_enc !== 32'h0000_5002) begin fails++; $display("FAIL flush_head_kept: got %h want 00005002", b_enc); end
        push_one(32'h0000_5005, 32'h0000_0055);
        tests++; if (b_abort !== 1'b0 || b_q_count !== 3'd2)
            begin fails++; $display("FAIL flush_after: got abort=%b q=%0d want 0/2", b_abort, b_q_count); end
        cop_insn_ack = 1'b1; cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd7;
        fin = 0; dones = 0;
        for (int i = 0; i < 12; i++) begin
            cop_wdata = 32'h0000_0100 + 32'(fin);
            if (b_ack === 1'b1) fin++;
            step();
            if (b_wb_done === 1'b1) dones++;
        end
        clear_inputs();
        tests++; if (fin != 4)   begin fails++; $display("FAIL flush_finishes: got %0d want 4", fin); end
        tests++; if (dones != 1) begin fails++; $display("FAIL flush_dropped: got %0d retires want 1", dones); end
        tests++; if (b_wb_data !== 32'h0000_0103 || b_wb_addr !== 5'd7)
            begin fails++; $display("FAIL flush_survivor_wb: got %h@%0d want 00000103@7", b_wb_data, b_wb_addr); end
        tests++; if (b_out_count !== 3'd0 || b_q_count !== 3'd0)
            begin fails++; $display("FAIL flush_drained: got out=%0d q=%0d want 0/0", b_out_count, b_q_count); end
    endtask

    task automatic test_err;
        do_reset();
        cop_insn_ack = 1'b1;
        push_one(32'h0000_6000, 32'h0000_0060);
        step();
        cop_insn_ack = 1'b0;
        tests++; if (a_out_count !== 3'd1) begin fails++; $display("FAIL err_issued: got %0d want 1", a_out_count); end
        cop_insn_rsp = 1'b1; cop_result = 3'd3; cop_wen = 1'b1; cop_waddr = 5'd0; cop_wdata = 32'h0000_CAFE;
        step();
        clear_inputs();
        tests++; if (a_wb_done !== 1'b1 || a_wb_result !== 3'd3 || a_wb_valid !== 1'b0)
            begin fails++; $display("FAIL err_retire: got done=%b res=%0d valid=%b want 1/3/0", a_wb_done, a_wb_result, a_wb_valid); end
        tests++; if (a_err !== 1'b1) begin fails++; $display("FAIL err_sticky_set: got %b want 1", a_err); end
        tests++; if (a_wb_addr !== 5'd0 || a_wb_data !== 32'd0)
            begin fails++; $display("FAIL err_wb_held: got %0d/%h want 0/00000000", a_wb_addr, a_wb_data); end
        step();
        tests++; if (a_wb_done !== 1'b0 || a_err !== 1'b1)
            begin fails++; $display("FAIL err_pulse_end: got done=%b err=%b want 0/1", a_wb_done, a_err); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (a_err !== 1'b0 || a_abort !== 1'b1)
            begin fails++; $display("FAIL err_flush_clear: got err=%b abort=%b want 0/1", a_err, a_abort); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        cop_insn_ack = 1'b1;
        push_one(32'h0000_7000, 32'h0000_0070);
        push_one(32'h0000_7001, 32'h0000_0071);
        cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd9;
        #2;
        g_resetn = 1'b0;
        #1;
        tests++; if (a_q_count !== 3'd0 || a_out_count !== 3'd0 || a_req !== 1'b0)
            begin fails++; $display("FAIL rstmid_state: got q=%0d out=%0d req=%b want 0/0/0", a_q_count, a_out_count, a_req); end
        step();
        clear_inputs();
        g_resetn = 1'b1;
        step();
        tests++; if (a_wb_done !== 1'b0 || a_wb_valid !== 1'b0 || a_wb_addr !== 5'd0)
            begin fails++; $display("FAIL rstmid_no_wb: got done=%b valid=%b addr=%0d want 0/0/0", a_wb_done, a_wb_valid, a_wb_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #2;
        test_reset();
        test_basic();
        test_fill();
        test_hold();
        test_max_out();
        test_flush();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
